// File: rtl/robs_mult_seq.sv
// Robertson's sequential multiplier: WIDTH-bit signed/unsigned operands, one
// add/shift iteration per clock, start/ready/done handshake, 2*WIDTH-bit product.
module robs_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_m;
  logic              r_mode;
  logic [CW-1:0]     r_count;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_iter;
  logic              w_last;
  logic [WIDTH:0]    w_ext_a;
  logic [WIDTH:0]    w_ext_m;
  logic [WIDTH:0]    w_sum;

  assign w_last = (r_count == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_iter      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CALC;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        w_iter = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Partial-product sum; the final signed step subtracts M because the
  // multiplier's MSB carries negative weight in two's complement.
  always_comb begin
    w_ext_a = r_mode ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
    w_ext_m = r_mode ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
    w_sum   = w_ext_a;
    if (!r_q[0]) begin
      w_sum = w_ext_a;
    end else if (r_mode && w_last) begin
      w_sum = w_ext_a - w_ext_m;
    end else begin
      w_sum = w_ext_a + w_ext_m;
    end
  end

  // Operand load and add/shift datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      r_m     <= {WIDTH{1'b0}};
      r_mode  <= 1'b0;
      r_count <= {CW{1'b0}};
    end else if (w_load) begin
      r_a     <= {WIDTH{1'b0}};
      r_q     <= multiplier;
      r_m     <= multiplicand;
      r_mode  <= signed_mode;
      r_count <= {CW{1'b0}};
    end else if (w_iter) begin
      r_a     <= w_sum[WIDTH:1];
      r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
      r_count <= r_count + CW'(1);
    end else begin
      r_a     <= r_a;
      r_q     <= r_q;
      r_count <= r_count;
    end
  end

  // Registered handshake outputs, decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = {r_a, r_q};

endmodule

// File: tb/tb_robs_mult_seq.sv
// Self-checking bench for robs_mult_seq at WIDTH=8 and WIDTH=16: directed
// corner cases plus random operands checked against an arithmetic model.
module tb_robs_mult_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  m8 = 8'd0, q8 = 8'd0;
  logic        ready8, busy8, done8;
  logic [15:0] p8;
  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] m16 = 16'd0, q16 = 16'd0;
  logic        ready16, busy16, done16;
  logic [31:0] p16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  robs_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8),
    .ready(ready8), .busy(busy8), .done(done8), .product(p8)
  );

  robs_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(sm16),
    .multiplicand(m16), .multiplier(q16),
    .ready(ready16), .busy(busy16), .done(done16), .product(p16)
  );

  // Reference: exact integer product of the operands interpreted per mode.
  function automatic logic [63:0] ref_prod(input int w, input bit sm,
                                           input logic [31:0] m, input logic [31:0] q);
    longint a, b, mask;
    mask = (longint'(1) << w) - 1;
    a = longint'(m) & mask;
    b = longint'(q) & mask;
    if (sm) begin
      if (a >= (longint'(1) << (w - 1))) a = a - (longint'(1) << w);
      if (b >= (longint'(1) << (w - 1))) b = b - (longint'(1) << w);
    end
    return 64'(a * b) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic [63:0] o_prod(input int w);
    return (w == 8) ? {48'd0, p8} : {32'd0, p16};
  endfunction
  function automatic logic o_ready(input int w);
    return (w == 8) ? ready8 : ready16;
  endfunction
  function automatic logic o_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic o_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic sm,
                       input logic [31:0] m, input logic [31:0] q);
    if (w == 8) begin
      start8 = s; sm8 = sm; m8 = m[7:0]; q8 = q[7:0];
    end else begin
      start16 = s; sm16 = sm; m16 = m[15:0]; q16 = q[15:0];
    end
  endtask

  // One full operation: accept, w iterations, DONE, back to IDLE.
  task automatic run_op(input int w, input bit sm, input logic [31:0] m,
                        input logic [31:0] q, input logic [63:0] exp,
                        input bit inject, input string tag);
    @(negedge clk);
    chk({tag, ":ready_pre"}, 64'(o_ready(w)), 64'd1);
    drive(w, 1'b1, sm, m, q);
    @(posedge clk); #1;
    drive(w, 1'b0, ~sm, $urandom, $urandom);
    chk({tag, ":busy"}, {62'd0, o_busy(w), o_ready(w)}, 64'd2);
    for (int i = 1; i <= w + 1; i++) begin
      drive(w, inject && (i == 3 || i == 9), 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      if (i < w) begin
        chk({tag, ":done_early"}, 64'(o_done(w)), 64'd0);
      end else if (i == w) begin
        chk({tag, ":done"}, 64'(o_done(w)), 64'd1);
        chk({tag, ":product"}, o_prod(w), exp);
      end else begin
        chk({tag, ":idle_after"}, {61'd0, o_done(w), o_busy(w), o_ready(w)}, 64'd1);
        chk({tag, ":product_held"}, o_prod(w), exp);
      end
    end
    drive(w, 1'b0, 1'b0, 32'd0, 32'd0);
    if (inject) begin
      @(posedge clk); #1;
      chk({tag, ":not_queued"}, {62'd0, o_busy(w), o_ready(w)}, 64'd1);
      chk({tag, ":product_kept"}, o_prod(w), exp);
    end
  endtask

  initial begin
    #12;
    chk("rst8", {p8, 13'd0, ready8, busy8, done8}, 64'h4);
    chk("rst16", {p16, 13'd0, ready16, busy16, done16}, 64'h4);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(8, 1'b1, 32'hFD, 32'h05, 64'hFFF1, 1'b0, "s_m3x5");
    run_op(8, 1'b1, 32'h80, 32'h80, 64'h4000, 1'b0, "s_minxmin");
    run_op(8, 1'b1, 32'h7F, 32'h80, 64'hC080, 1'b0, "s_maxxmin");
    run_op(8, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 1'b0, "u_ffxff");
    run_op(8, 1'b1, 32'hFF, 32'hFF, 64'h0001, 1'b0, "s_ffxff");
    run_op(8, 1'b1, 32'h06, 32'h07, 64'h002A, 1'b1, "s_6x7_ignore");

    // Abort mid-calculation with an asynchronous reset.
    @(negedge clk);
    drive(8, 1'b1, 1'b1, 32'h5A, 32'hC3);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid", {p8, 13'd0, ready8, busy8, done8}, 64'h4);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(8, 1'b1, 32'h02, 32'hFC, 64'hFFF8, 1'b0, "s_2xm4");

    run_op(16, 1'b1, 32'hFFFF, 32'hFFFF, 64'h0000_0001, 1'b0, "s16_m1xm1");
    run_op(16, 1'b0, 32'hFFFF, 32'h0002, 64'h0001_FFFE, 1'b0, "u16_ffffx2");
    run_op(16, 1'b1, 32'h8000, 32'h8000, 64'h4000_0000, 1'b0, "s16_minxmin");

    for (int k = 0; k < 24; k++) begin
      int          w;
      bit          sm;
      logic [31:0] m, q;
      w  = (k % 2 == 0) ? 8 : 16;
      sm = 1'($urandom);
      m  = $urandom;
      q  = $urandom;
      run_op(w, sm, m, q, ref_prod(w, sm, m, q), 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/robs_mult_seq.md
Name: robs_mult_seq

Overview:
- Self-contained, parametrised Robertson's multiplier with its own control FSM, iteration counter and shift datapath.
- Multiplies two WIDTH-bit operands into a 2*WIDTH-bit product at one add/shift iteration per clock.
- Supports signed (two's complement) or unsigned operation, selected per operation.
- Sits behind a start/ready/done handshake, so a host FSM or bus wrapper can issue back-to-back multiplies without driving individual control lines.

Parameters:
WIDTH  8  operand width in bits; legal 2..32; product is 2*WIDTH bits

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when ready=1
signed_mode  input  1  1 = operands two's complement, 0 = unsigned; sampled with start
multiplicand  input  WIDTH  M operand; sampled with start
multiplier  input  WIDTH  Q operand; sampled with start
ready  output  1  high in IDLE only
busy  output  1  high in CALC and DONE
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  {A,Q} result; held until the next accepted start

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, A=0, Q=0, M=0, count=0, product=0, done=0, busy=0, ready=1. Reset asserted mid-CALC aborts the operation with no partial result retained.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge k → load M=multiplicand, Q=multiplier, A=0, mode=signed_mode, count=0; go to CALC.
  - start=0 → stay.
- CALC (one iteration per edge, iterations i=0..WIDTH-1):
  - Extend A and M to WIDTH+1 bits: sign-extension if mode=1, zero-extension if mode=0.
  - If Q[0]=0: sum = ext(A).
  - If Q[0]=1 and i<WIDTH-1: sum = ext(A)+ext(M).
  - If Q[0]=1 and i=WIDTH-1: sum = ext(A)−ext(M) when mode=1 (Robertson correction); ext(A)+ext(M) when mode=0.
  - Update: A ← sum[WIDTH:1]; Q ← {sum[0], Q[WIDTH-1:1]}; count ← count+1.
  - After the i=WIDTH-1 edge (edge k+WIDTH): go to DONE.
  - Counter width is clog2(WIDTH)+1; it never wraps within an operation.
- DONE:
  - done=1 for exactly this cycle (cycle following edge k+WIDTH); product={A,Q}.
  - Next edge → IDLE.
- Latency: done high WIDTH+1 cycles after the start-accept edge. Next start can be accepted at the edge ending DONE+1, giving a throughput of 1 result per WIDTH+2 cycles.
- start while busy=1 (CALC or DONE) is ignored: not queued, no operand or mode change.
- Operand and signed_mode inputs may change freely after acceptance without affecting the result.
- product is driven from the A/Q registers:
  - Stable from DONE until the next accepted start.
  - Undefined during CALC; the host must use done.
- Signed extreme cases are exact, with no overflow: (−2^(W−1))·(−2^(W−1)) = 2^(2W−2).
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, signed, M=-3 (0xFD), Q=5 → product=0xFFF1 (−15); done pulses exactly 9 cycles after the accept edge, for 1 cycle; ready returns next cycle.
- WIDTH=8, signed, M=0x80, Q=0x80 → product=0x4000 (+16384); then M=0x7F, Q=0x80 → 0xC080 (−16256).
- WIDTH=8, unsigned, M=0xFF, Q=0xFF → product=0xFE01 (65025); same operands signed → 0x0001.
- WIDTH=8, signed 6×7 in flight, then start pulsed at cycles 3 and 9 with M=Q=0xFF → ignored; product=0x002A, single done pulse.
- WIDTH=8: drop reset_n during CALC iteration 4 → immediately ready=1, busy=0, done=0, product=0. A new signed 2×−4 → 0xFFF8.
- WIDTH=16, signed 0xFFFF×0xFFFF → product=0x00000001, done 17 cycles after accept; unsigned 0xFFFF×0x0002 → 0x0001FFFE.
